toast_hazard_ctrl: RTL

Pipeline hazard and stall controller for the Toast RV32I 5-stage core. It sits beside the operand forwarding unit and handles the cases forwarding cannot resolve:
- load-use interlocks;
- taken-branch flushes, with branches resolved in EX;
- data-memory wait states, via a dmem req/ready handshake.

It drives the stall and flush enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps a memory-wait watchdog and saturating performance counters.

---
 rtl/toast_hazard_pkg.sv | 19 +
 rtl/toast_sat_counter.sv | 30 +++
 rtl/toast_hazard_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/toast_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : toast_hazard_pkg
//  Brief    : Shared types and constants for the Toast hazard/stall controller
//  Revision : 1.0 - initial release
// ============================================================================
package toast_hazard_pkg;

    // Controller FSM: normal flow, or waiting on an outstanding dmem access
    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    // Canonical RV32I NOP (addi x0, x0, 0) loaded by flushing stages
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

endpackage : toast_hazard_pkg
`default_nettype wire

// File: rtl/toast_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : toast_sat_counter
//  Brief    : Up-counter that sticks at all-ones instead of wrapping
//  Revision : 1.0 - initial release
// ============================================================================
module toast_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    // Count enabled cycles, holding at the maximum value once reached
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule : toast_sat_counter
`default_nettype wire

// File: rtl/toast_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : toast_hazard_ctrl
//  Brief    : Load-use interlock, taken-branch flush and dmem wait-state
//             control for the Toast RV32I 5-stage pipeline, with a dmem
//             timeout watchdog and saturating stall/flush counters.
//  Revision : 1.0 - initial release
// ============================================================================
module toast_hazard_ctrl
    import toast_hazard_pkg::*;
#(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH          = 32,
    parameter int MEM_TIMEOUT        = 255
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rs1_addr_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rs2_addr_i,
    input  logic                          ID_rs1_used_i,
    input  logic                          ID_rs2_used_i,
    input  logic                          EX_mem_rd_en_i,
    input  logic [REGFILE_ADDR_WIDTH-1:0] EX_rd_addr_i,
    input  logic                          EX_branch_taken_i,
    input  logic                          MEM_dmem_req_i,
    input  logic                          MEM_dmem_ready_i,
    output logic                          PC_stall_o,
    output logic                          IF_ID_stall_o,
    output logic                          IF_ID_flush_o,
    output logic                          ID_EX_stall_o,
    output logic                          ID_EX_flush_o,
    output logic                          EX_MEM_stall_o,
    output logic                          MEM_WB_flush_o,
    output logic                          bus_err_o,
    output logic [CNT_WIDTH-1:0]          stall_cnt_o,
    output logic [CNT_WIDTH-1:0]          flush_cnt_o
);

    // Wait counter only needs to reach MEM_TIMEOUT
    localparam int                 c_wait_w    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max  = c_wait_w'(MEM_TIMEOUT);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_TIMEOUT - 1);

    hz_state_t           r_state;
    hz_state_t           w_next_state;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_bus_err;

    logic w_load_use;
    logic w_mem_busy;
    logic w_branch_flush;

    // x0 is never a real dependency, so a load into x0 cannot interlock
    assign w_load_use = EX_mem_rd_en_i && (EX_rd_addr_i != '0) &&
                        (((EX_rd_addr_i == ID_rs1_addr_i) && ID_rs1_used_i) ||
                         ((EX_rd_addr_i == ID_rs2_addr_i) && ID_rs2_used_i));

    // Ready in the same cycle as req is a zero-wait access
    assign w_mem_busy = MEM_dmem_req_i && !MEM_dmem_ready_i;

    // Next-state and prioritised stall/flush decode (mem > branch > load-use)
    always_comb begin
        w_next_state   = r_state;
        PC_stall_o     = 1'b0;
        IF_ID_stall_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_stall_o  = 1'b0;
        ID_EX_flush_o  = 1'b0;
        EX_MEM_stall_o = 1'b0;
        MEM_WB_flush_o = 1'b0;
        w_branch_flush = 1'b0;

        case (r_state)
            HZ_RUN: begin
                if (w_mem_busy) begin
                    w_next_state = HZ_MEM_WAIT;
                end
            end
            HZ_MEM_WAIT: begin
                if (MEM_dmem_ready_i || !MEM_dmem_req_i) begin
                    w_next_state = HZ_RUN;
                end
            end
            default: w_next_state = HZ_RUN;
        endcase

        if (!Rst) begin
            if (w_mem_busy) begin
                // Freeze everything upstream of MEM; WB receives a bubble
                PC_stall_o     = 1'b1;
                IF_ID_stall_o  = 1'b1;
                ID_EX_stall_o  = 1'b1;
                EX_MEM_stall_o = 1'b1;
                MEM_WB_flush_o = 1'b1;
            end else if (EX_branch_taken_i) begin
                // Squash the two younger instructions; any load-use on them is moot
                IF_ID_flush_o  = 1'b1;
                ID_EX_flush_o  = 1'b1;
                w_branch_flush = 1'b1;
            end else if (w_load_use) begin
                // Hold fetch/decode one cycle and insert a bubble into EX
                PC_stall_o     = 1'b1;
                IF_ID_stall_o  = 1'b1;
                ID_EX_flush_o  = 1'b1;
            end
        end
    end

    // State register, memory-wait watchdog and sticky timeout flag
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= HZ_RUN;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == HZ_RUN) begin
                r_wait_cnt <= '0;
            end else if ((r_state == HZ_MEM_WAIT) && (r_wait_cnt != c_wait_max)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            // Flag as the count steps onto MEM_TIMEOUT while still waiting
            if ((r_state == HZ_MEM_WAIT) && (w_next_state == HZ_MEM_WAIT) &&
                (r_wait_cnt >= c_wait_last)) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_err_o = r_bus_err;

    toast_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc_i (PC_stall_o),
        .cnt_o (stall_cnt_o)
    );

    toast_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .inc_i (w_branch_flush),
        .cnt_o (flush_cnt_o)
    );

endmodule : toast_hazard_ctrl
`default_nettype wire
